// File: rtl/dir_input_encoder.sv
// Pushbutton front end for the snake game: synchronize, debounce, pick one press
// per cycle and apply the no-reversal rule. Define DIR_TURN_BUFFER_EN to queue turns until move_tick.
module dir_input_encoder #(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int CNT_W           = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] pb_i,
  input  logic       enable,
`ifdef DIR_TURN_BUFFER_EN
  input  logic       move_tick,
`endif
  output logic [3:0] direction,
  output logic [1:0] dir_code,
  output logic       dir_strobe,
  output logic       reject_pulse
);

  // Encoding equals the bit position in pb_i/direction; opposites differ only in bit 0.
  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_UP    = 2'd3
  } dir_e;

  function automatic dir_e opposite(input dir_e d);
    return dir_e'(d ^ 2'd1);
  endfunction

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       stable_q, stable_d;
  logic [3:0]       press_q, press_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  dir_e             head_q, head_d;
  logic             strobe_q, strobe_d;
  logic             reject_q, reject_d;
  logic             evt_valid;
  dir_e             evt_code;

  // NOTE: every register here, the small counter array included, is reset; a
  // mid-debounce reset must discard partial counts, so nothing is left to power-up state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      press_q  <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so each flop samples the pre-edge value of
      // its neighbour; blocking here would collapse the two synchronizer stages.
      sync1_q  <= pb_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // NOTE: each combinational output gets a default before any branch, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) stable_d[i] = ~stable_q[i];
        else                                          cnt_d[i]    = cnt_q[i] + CNT_W'(1);
      end
    end
    press_d = stable_d & ~stable_q;
  end

  always_comb begin
    evt_valid = |press_q;
    evt_code  = DIR_RIGHT;
    if      (press_q[3]) evt_code = DIR_UP;
    else if (press_q[2]) evt_code = DIR_DOWN;
    else if (press_q[1]) evt_code = DIR_LEFT;
  end

`ifdef DIR_TURN_BUFFER_EN
  dir_e       fifo_q [2];
  dir_e       fifo_d [2];
  logic [1:0] count_q, count_d;
  logic [1:0] level;
  dir_e       ref_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q[0] <= DIR_RIGHT;
      fifo_q[1] <= DIR_RIGHT;
      count_q   <= '0;
    end else begin
      fifo_q    <= fifo_d;
      count_q   <= count_d;
    end
  end

  // Presses are judged against where the snake will be heading once the queue drains.
  always_comb begin
    head_d   = head_q;
    strobe_d = 1'b0;
    reject_d = 1'b0;
    fifo_d   = fifo_q;
    level    = count_q;
    ref_code = (count_q == 2'd2) ? fifo_q[1] : (count_q == 2'd1) ? fifo_q[0] : head_q;
    if (move_tick && count_q != 2'd0) begin
      head_d    = fifo_q[0];
      strobe_d  = 1'b1;
      fifo_d[0] = fifo_q[1];
      level     = count_q - 2'd1;
    end
    if (enable && evt_valid) begin
      if (count_q == 2'd2 || evt_code == opposite(ref_code)) begin
        reject_d = 1'b1;
      end else if (evt_code != ref_code) begin
        fifo_d[level[0]] = evt_code;
        level            = level + 2'd1;
      end
    end
    count_d = level;
  end
`else
  always_comb begin
    head_d   = head_q;
    strobe_d = 1'b0;
    reject_d = 1'b0;
    if (enable && evt_valid) begin
      if (evt_code == opposite(head_q)) begin
        reject_d = 1'b1;
      end else if (evt_code != head_q) begin
        head_d   = evt_code;
        strobe_d = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q   <= DIR_RIGHT;
      strobe_q <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      strobe_q <= strobe_d;
      reject_q <= reject_d;
    end
  end

  // Heading is held as a code, so the one-hot view cannot ever have zero or two bits set.
  assign direction    = 4'b0001 << head_q;
  assign dir_code     = head_q;
  assign dir_strobe   = strobe_q;
  assign reject_pulse = reject_q;

endmodule

// File: tb/tb_dir_input_encoder.sv
// Self-checking bench for dir_input_encoder (default build): directed table,
// hand-written timing sequences and a randomized run against a reference model.
module tb_dir_input_encoder;

  localparam int DEB = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] pb_i = '0;
  logic       enable = 1'b1;
  logic       move_tick = 1'b0;
  logic [3:0] direction;
  logic [1:0] dir_code;
  logic       dir_strobe;
  logic       reject_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  int s_cnt = 0;
  int r_cnt = 0;
  bit model_on = 0;

  dir_input_encoder #(.DEBOUNCE_CYCLES(DEB), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .pb_i         (pb_i),
    .enable       (enable),
`ifdef DIR_TURN_BUFFER_EN
    .move_tick    (move_tick),
`endif
    .direction    (direction),
    .dir_code     (dir_code),
    .dir_strobe   (dir_strobe),
    .reject_pulse (reject_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: heading kept as an index 0..3 (right,left,down,up); each button
  // flips when DEB consecutive samples (seen two edges late) disagree with it.
  localparam int OPP [4] = '{1, 0, 3, 2};
  localparam logic [3:0] ONEHOT [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  int         m_run [4];
  bit   [3:0] m_stab, m_h1, m_h2;
  int         m_pend, m_head;
  bit         m_strobe, m_rej;

  task automatic m_reset();
    for (int b = 0; b < 4; b++) m_run[b] = 0;
    m_stab = '0; m_h1 = '0; m_h2 = '0;
    m_pend = -1; m_head = 0; m_strobe = 0; m_rej = 0;
  endtask

  task automatic m_edge(input bit [3:0] pb, input bit en);
    bit [3:0] seen;
    bit [3:0] rose;
    m_strobe = 0;
    m_rej    = 0;
    if (en && m_pend >= 0) begin
      if (m_pend == OPP[m_head]) m_rej = 1;
      else if (m_pend != m_head) begin
        m_head   = m_pend;
        m_strobe = 1;
      end
    end
    seen = m_h2;
    m_h2 = m_h1;
    m_h1 = pb;
    rose = '0;
    for (int b = 0; b < 4; b++) begin
      if (seen[b] != m_stab[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB) begin
          m_stab[b] = ~m_stab[b];
          m_run[b]  = 0;
          rose[b]   = m_stab[b];
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_pend = -1;
    for (int b = 0; b < 4; b++) if (rose[b]) m_pend = b;
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (model_on) m_edge(pb_i, enable);
      #1;
      if (dir_strobe)   s_cnt++;
      if (reject_pulse) r_cnt++;
      if (model_on) begin
        check("rand_direction", 32'(direction), 32'(ONEHOT[m_head]));
        check("rand_dir_code", 32'(dir_code), 32'(m_head));
        check("rand_strobe", 32'(dir_strobe), 32'(m_strobe));
        check("rand_reject", 32'(reject_pulse), 32'(m_rej));
      end
    end
  endtask

  task automatic do_reset();
    model_on = 0;
    pb_i = '0;
    enable = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    s_cnt = 0;
    r_cnt = 0;
  endtask

  typedef struct {
    string      name;
    logic [3:0] pb1;
    logic [3:0] pb2;
    logic       en;
    logic [3:0] exp_dir;
    int         exp_strobes;
    int         exp_rejects;
  } vec_t;

  vec_t vecs [9];
  int hold;

  initial begin
    vecs[0] = '{"down",          4'b0100, 4'b0000, 1'b1, 4'b0100, 1, 0};
    vecs[1] = '{"left_reverse",  4'b0010, 4'b0000, 1'b1, 4'b0001, 0, 1};
    vecs[2] = '{"up_then_right", 4'b1000, 4'b0001, 1'b1, 4'b0001, 2, 0};
    vecs[3] = '{"up_and_down",   4'b1100, 4'b0000, 1'b1, 4'b1000, 1, 0};
    vecs[4] = '{"up_then_down",  4'b1000, 4'b0100, 1'b1, 4'b1000, 1, 1};
    vecs[5] = '{"same_right",    4'b0001, 4'b0000, 1'b1, 4'b0001, 0, 0};
    vecs[6] = '{"left_and_right",4'b0011, 4'b0000, 1'b1, 4'b0001, 0, 1};
    vecs[7] = '{"all_four",      4'b1111, 4'b0000, 1'b1, 4'b1000, 1, 0};
    vecs[8] = '{"disabled_up",   4'b1000, 4'b0000, 1'b0, 4'b0001, 0, 0};

    // Reset values while reset is asserted, then an idle stretch.
    tick(1);
    check("reset_direction", 32'(direction), 32'h1);
    check("reset_dir_code", 32'(dir_code), 32'h0);
    check("reset_strobe", 32'(dir_strobe), 32'h0);
    check("reset_reject", 32'(reject_pulse), 32'h0);
    do_reset();
    tick(20);
    check("idle_direction", 32'(direction), 32'h1);
    check("idle_dir_code", 32'(dir_code), 32'h0);
    check("idle_pulses", 32'(s_cnt + r_cnt), 32'h0);

    // Exact latency: press present before edge N, heading changes at edge N+4.
    do_reset();
    tick(9);
    pb_i = 4'b0100;
    tick(4);
    check("lat_before_dir", 32'(direction), 32'h1);
    check("lat_before_strobe", 32'(dir_strobe), 32'h0);
    tick(1);
    check("lat_dir", 32'(direction), 32'h4);
    check("lat_code", 32'(dir_code), 32'h2);
    check("lat_strobe", 32'(dir_strobe), 32'h1);
    tick(1);
    check("lat_strobe_single", 32'(dir_strobe), 32'h0);
    check("lat_dir_held", 32'(direction), 32'h4);

    // One-cycle glitch must not pass the debouncer.
    do_reset();
    pb_i = 4'b1000;
    tick(1);
    pb_i = 4'b0000;
    tick(10);
    check("glitch_dir", 32'(direction), 32'h1);
    check("glitch_pulses", 32'(s_cnt + r_cnt), 32'h0);

    // Button already stable-high when enable rises gives no event until re-pressed.
    do_reset();
    enable = 1'b0;
    pb_i = 4'b1000;
    tick(8);
    enable = 1'b1;
    tick(8);
    check("en_rise_dir", 32'(direction), 32'h1);
    check("en_rise_strobes", 32'(s_cnt), 32'h0);
    pb_i = 4'b0000;
    tick(8);
    pb_i = 4'b1000;
    tick(8);
    check("en_repress_dir", 32'(direction), 32'h8);
    check("en_repress_strobes", 32'(s_cnt), 32'h1);

    // Reset mid-debounce: partial count lost, held button seen after full latency.
    do_reset();
    pb_i = 4'b0100;
    tick(3);
    rst = 1'b1;
    tick(1);
    check("midrst_dir", 32'(direction), 32'h1);
    rst = 1'b0;
    s_cnt = 0;
    tick(4);
    check("midrst_early_dir", 32'(direction), 32'h1);
    check("midrst_early_strobe", 32'(s_cnt), 32'h0);
    tick(1);
    check("midrst_dir_after", 32'(direction), 32'h4);
    check("midrst_strobe", 32'(dir_strobe), 32'h1);

    // Table of two-press scenarios from reset.
    for (int v = 0; v < 9; v++) begin
      do_reset();
      enable = vecs[v].en;
      pb_i = vecs[v].pb1;
      tick(8);
      pb_i = '0;
      tick(8);
      pb_i = vecs[v].pb2;
      tick(8);
      pb_i = '0;
      tick(8);
      check({vecs[v].name, "_dir"}, 32'(direction), 32'(vecs[v].exp_dir));
      check({vecs[v].name, "_strobes"}, 32'(s_cnt), 32'(vecs[v].exp_strobes));
      check({vecs[v].name, "_rejects"}, 32'(r_cnt), 32'(vecs[v].exp_rejects));
    end

    // Randomized run against the reference model.
    do_reset();
    m_reset();
    model_on = 1;
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        pb_i   = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
        enable = ($urandom_range(0, 9) != 0);
        hold   = $urandom_range(1, 8);
      end
      hold--;
      tick(1);
    end
    model_on = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
